// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and helpers
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int PIX_DIV_DEF   = 4;
  localparam int CNT_W         = 10;

  // Both sync pulses are active-low for the 640x480 family of modes.
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic in_window(logic [CNT_W-1:0] cnt, int lo, int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_pix_tick_gen.sv
// rtl/vga_timing_pix_tick_gen.sv - free-running divider producing the one-clk pixel tick
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = PIX_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, sync generation and registered RGB444 output
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int PIX_DIV   = PIX_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_data,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);

  logic             pix_tick;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             h_end;
  logic             v_end;
  logic             unused_pix_bits;

  pix_tick_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  assign h_end    = (h_cnt_q == H_LAST);
  assign v_end    = (v_cnt_q == V_LAST);
  assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign pos_x    = video_on ? h_cnt_q : '0;
  assign pos_y    = video_on ? v_cnt_q : '0;

  // Only the top nibble of each 8-bit channel reaches the RGB444 DAC.
  assign unused_pix_bits = ^{pix_data[19:16], pix_data[11:8], pix_data[3:0]};

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_tick) begin
      h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
      if (h_end) begin
        v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
      end
      // Sync and colour are registered from the same counter state so they stay aligned.
      hsync_d = in_window(h_cnt_q, H_SYNC_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = in_window(v_cnt_q, V_SYNC_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_d   = video_on ? {pix_data[23:20], pix_data[15:12], pix_data[7:4]} : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - randomized self-checking bench for vga_timing against a raster arithmetic model
module tb_vga_timing;

  typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb, pd;} tp_t;
  typedef struct {int px, py, von, hs, vs, rgb, fs;} exp_t;

  localparam int SH_V = 20, SH_F = 3, SH_S = 5, SH_B = 4;
  localparam int SV_V = 12, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_PD = 3;
  localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_V + SV_F + SV_S + SV_B;
  localparam int S_FRAME = S_HT * S_VT * S_PD;

  tp_t pa = '{640, 16, 96, 48, 480, 10, 2, 33, 4};
  tp_t pb = '{SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, S_PD};

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int mode_a = 0;
  int seed_b = 0;
  int e_a = 0;
  int e_b = 0;

  logic [23:0] pix_a, pix_b;
  logic [9:0]  pos_x_a, pos_y_a, pos_x_b, pos_y_b;
  logic        von_a, hs_a, vs_a, fs_a, von_b, hs_b, vs_b, fs_b;
  logic [11:0] rgb_a, rgb_b;

  function automatic int pix_fn(int mode, int seed, int x, int y);
    case (mode)
      0:       return 32'hFF8010;
      1:       return (x == 0) ? 32'hFFFFFF : 0;
      default: return (((x * 13 + seed) & 255) << 16) | (((y * 29) ^ (seed >> 8)) & 255) << 8
                      | ((x ^ y ^ (seed >> 16)) & 255);
    endcase
  endfunction

  function automatic int to444(int p);
    return (((p >> 20) & 15) << 8) | (((p >> 12) & 15) << 4) | ((p >> 4) & 15);
  endfunction

  // Raster position from the number of clocks since reset release.
  function automatic exp_t model(tp_t p, int e, int mode, int seed);
    exp_t x;
    int ht, vt, n, h, v, hp, vp;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    n  = e / p.pd;
    h  = n % ht;
    v  = (n / ht) % vt;
    x.von = (h < p.hv && v < p.vv) ? 1 : 0;
    x.px  = (x.von != 0) ? h : 0;
    x.py  = (x.von != 0) ? v : 0;
    x.fs  = ((e % p.pd) == p.pd - 1 && h == 0 && v == 0) ? 1 : 0;
    if (n == 0) begin
      x.hs = 1; x.vs = 1; x.rgb = 0;
    end else begin
      hp = (n - 1) % ht;
      vp = ((n - 1) / ht) % vt;
      x.hs  = (hp >= p.hv + p.hf && hp < p.hv + p.hf + p.hs) ? 0 : 1;
      x.vs  = (vp >= p.vv + p.vf && vp < p.vv + p.vf + p.vs) ? 0 : 1;
      x.rgb = (hp < p.hv && vp < p.vv) ? to444(pix_fn(mode, seed, hp, vp)) : 0;
    end
    return x;
  endfunction

  assign pix_a = 24'(pix_fn(mode_a, 0, int'(pos_x_a), int'(pos_y_a)));
  assign pix_b = 24'(pix_fn(2, seed_b, int'(pos_x_b), int'(pos_y_b)));

  vga_timing dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_data(pix_a), .pos_x(pos_x_a), .pos_y(pos_y_a),
    .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_timing #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .PIX_DIV(S_PD)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_data(pix_b), .pos_x(pos_x_b), .pos_y(pos_y_b),
    .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  always @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) e_a <= 0;
    else          e_a <= e_a + 1;
  end

  always @(posedge clk or negedge rst_n_b) begin
    if (!rst_n_b) e_b <= 0;
    else          e_b <= e_b + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(string who, exp_t x, logic [9:0] px, logic [9:0] py, logic von,
                     logic hs, logic vs, logic [11:0] rgb, logic fs);
    check({who, ".pos_x"}, 32'(px), x.px);
    check({who, ".pos_y"}, 32'(py), x.py);
    check({who, ".video_on"}, 32'(von), x.von);
    check({who, ".hsync"}, 32'(hs), x.hs);
    check({who, ".vsync"}, 32'(vs), x.vs);
    check({who, ".rgb"}, 32'(rgb), x.rgb);
    check({who, ".frame_start"}, 32'(fs), x.fs);
  endtask

  // Directed timing observations on the default-parameter instance.
  bit track_a = 1'b0;
  int first_fs_a = -1, fall0_a = -1, fall1_a = -1, low_a = 0;
  logic hs_prev_a = 1'b1;

  // Pulse-width and frame-period observations on the small instance.
  int last_fs_b = -1, vlow_b = 0, hlow_b = 0, clk_abs = 0;
  logic vs_prev_b = 1'b1, hs_prev_b = 1'b1;

  initial forever begin
    @(negedge clk);
    clk_abs++;
    cmp("a", model(pa, e_a, mode_a, 0), pos_x_a, pos_y_a, von_a, hs_a, vs_a, rgb_a, fs_a);
    cmp("b", model(pb, e_b, 2, seed_b), pos_x_b, pos_y_b, von_b, hs_b, vs_b, rgb_b, fs_b);
    if (track_a) begin
      if (fs_a && first_fs_a < 0) first_fs_a = e_a + 1;
      if (hs_prev_a && !hs_a) begin
        if (fall0_a < 0) fall0_a = e_a;
        else if (fall1_a < 0) fall1_a = e_a;
      end
      if (!hs_a) low_a++;
    end
    hs_prev_a = hs_a;
    if (fs_b) begin
      if (last_fs_b < 0) check("b.first_fs_edge", 32'(e_b + 1), S_PD);
      else               check("b.frame_period", 32'(clk_abs - last_fs_b), S_FRAME);
      last_fs_b = clk_abs;
    end
    if (!vs_b) vlow_b++;
    if (!hs_b) hlow_b++;
    if (!vs_prev_b && vs_b) begin
      if (vlow_b > 0) check("b.vsync_low_clks", 32'(vlow_b), SV_S * S_HT * S_PD);
      vlow_b = 0;
    end
    if (!hs_prev_b && hs_b) begin
      if (hlow_b > 0) check("b.hsync_low_clks", 32'(hlow_b), SH_S * S_PD);
      hlow_b = 0;
    end
    vs_prev_b = vs_b;
    hs_prev_b = hs_b;
  end

  task automatic release_a();
    @(negedge clk);
    #2 rst_n_a = 1'b1;
  endtask

  task automatic seq_a();
    repeat (3) @(posedge clk);
    release_a();
    track_a = 1'b1;
    repeat (7000) @(posedge clk);
    track_a = 1'b0;
    check("a.first_fs_edge", 32'(first_fs_a), 4);
    check("a.hsync_fall_edge", 32'(fall0_a), 657 * 4);
    check("a.line_period", 32'(fall1_a - fall0_a), 3200);
    check("a.hsync_low_clks", 32'(low_a), 2 * 384);
    #2;
    rst_n_a = 1'b0;
    mode_a = 1;
    #1;
    check("a.async_rgb", 32'(rgb_a), 0);
    check("a.async_hsync", 32'(hs_a), 1);
    check("a.async_fs", 32'(fs_a), 0);
    repeat (3) @(posedge clk);
    release_a();
    repeat (6500) @(posedge clk);
  endtask

  task automatic reset_b_at(int th, int tv);
    int n;
    bit hit = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !hit; i++) begin
      @(posedge clk);
      #2;
      n = e_b / S_PD;
      if ((n % S_HT) == th && ((n / S_HT) % S_VT) == tv) hit = 1'b1;
    end
    check("b.reset_target_reached", 32'(hit), 1);
    rst_n_b = 1'b0;
    last_fs_b = -1;
    vlow_b = -(1 << 20);
    hlow_b = -(1 << 20);
    #1;
    check("b.async_hsync", 32'(hs_b), 1);
    check("b.async_vsync", 32'(vs_b), 1);
    check("b.async_rgb", 32'(rgb_b), 0);
    check("b.async_fs", 32'(fs_b), 0);
    check("b.async_pos_x", 32'(pos_x_b), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n_b = 1'b1;
    repeat (2 * S_FRAME + 50) @(posedge clk);
  endtask

  task automatic seq_b();
    seed_b = int'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n_b = 1'b1;
    repeat (2 * S_FRAME + 20) @(posedge clk);
    reset_b_at(12, 7);
    reset_b_at(SH_V + SH_F + 1, SV_V + SV_F);
    reset_b_at(int'($urandom_range(0, S_HT - 1)), int'($urandom_range(0, S_VT - 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fork
      seq_a();
      seq_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
